// File: rtl/egress_frame_arbiter_if.sv
// Bundles the per-port ingress streams, the shared egress stream and the
// Avalon register bus for the egress frame arbiter.
interface egress_frame_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [16*NUM_PORTS-1:0] ingress_port_tdata;
  logic [NUM_PORTS-1:0]    ingress_port_tlast;
  logic [NUM_PORTS-1:0]    ingress_port_tvalid;
  logic [NUM_PORTS-1:0]    ingress_port_tready;
  logic [15:0]             egress_port_tdata;
  logic                    egress_port_tlast;
  logic                    egress_port_tvalid;
  logic                    egress_port_tready;
  logic [7:0]              writedata;
  logic                    write;
  logic                    chipselect;
  logic [7:0]              address;
  logic                    read;
  logic [7:0]              readdata;

  modport slave (
    input  ingress_port_tdata, ingress_port_tlast, ingress_port_tvalid,
    output ingress_port_tready,
    output egress_port_tdata, egress_port_tlast, egress_port_tvalid,
    input  egress_port_tready,
    input  writedata, write, chipselect, address, read,
    output readdata
  );

  modport master (
    output ingress_port_tdata, ingress_port_tlast, ingress_port_tvalid,
    input  ingress_port_tready,
    input  egress_port_tdata, egress_port_tlast, egress_port_tvalid,
    output egress_port_tready,
    output writedata, write, chipselect, address, read,
    input  readdata
  );
endinterface

// File: rtl/egress_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one 16-bit AXI-stream egress
// between NUM_PORTS generators, with Avalon-readable per-port frame counters.
module egress_frame_arbiter #(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  egress_frame_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] next_grant;
  logic             request_seen;
  logic [7:0]       counter [NUM_PORTS];
  logic             transfer;
  logic             frame_done;
  logic             clear_counters;
  logic             reg_read;
  logic [7:0]       read_value;
  logic             unused_writedata;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_PORTS;
    return IDX_W'(sum);
  endfunction

  // Scan starts just after the previous winner so every port gets a turn.
  always_comb begin
    request_seen = 1'b0;
    next_grant   = last_grant;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!request_seen && bus.ingress_port_tvalid[wrap_idx(last_grant, k)]) begin
        request_seen = 1'b1;
        next_grant   = wrap_idx(last_grant, k);
      end
    end
  end

  always_comb begin
    bus.egress_port_tdata   = '0;
    bus.egress_port_tlast   = 1'b0;
    bus.egress_port_tvalid  = 1'b0;
    bus.ingress_port_tready = '0;
    if (state == BUSY) begin
      bus.egress_port_tdata          = bus.ingress_port_tdata[16*grant +: 16];
      bus.egress_port_tlast          = bus.ingress_port_tlast[grant];
      bus.egress_port_tvalid         = bus.ingress_port_tvalid[grant];
      bus.ingress_port_tready[grant] = bus.egress_port_tready;
    end
  end

  assign transfer         = (state == BUSY) && bus.ingress_port_tvalid[grant] && bus.egress_port_tready;
  assign frame_done       = transfer && bus.ingress_port_tlast[grant];
  assign clear_counters   = bus.chipselect && bus.write && (bus.address == 8'd15) && bus.writedata[0];
  assign reg_read         = bus.chipselect && bus.read;
  assign unused_writedata = ^bus.writedata[7:1];

  always_comb begin
    read_value = '0;
    if (int'(bus.address) < NUM_PORTS) begin
      read_value = counter[bus.address[IDX_W-1:0]];
    end else if (bus.address == 8'd8) begin
      read_value = {state == BUSY, 3'b000, 4'(grant)};
    end
  end

  // A software clear takes priority over an increment landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= IDX_W'(NUM_PORTS - 1);
      bus.readdata <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        counter[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (request_seen) begin
            grant <= next_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (frame_done) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (clear_counters) begin
          counter[i] <= '0;
        end else if (frame_done && (grant == IDX_W'(i))) begin
          counter[i] <= counter[i] + 8'd1;
        end
      end
      if (reg_read) begin
        bus.readdata <= read_value;
      end
    end
  end

endmodule

// File: tb/tb_egress_frame_arbiter.sv
// Directed vector tables plus a randomized run scored against a behavioural
// model of the round-robin frame arbiter and its counter registers.
module tb_egress_frame_arbiter;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic reset;

  egress_frame_arbiter_if #(.NUM_PORTS(NP)) bus ();

  egress_frame_arbiter #(.NUM_PORTS(NP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] tv;
    logic [NP-1:0] tl;
    logic [7:0]    tag;
    logic          rdy;
    logic          exp_valid;
    logic [15:0]   exp_data;
    logic          exp_last;
    logic [NP-1:0] exp_tready;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state for the randomized run.
  int            owner;
  int            last_w;
  int            mgrant;
  logic [7:0]    cnt [NP];
  logic [7:0]    exp_rd;
  int            beat [NP];
  int            flen [NP];
  int            fno  [NP];

  function automatic vec_t mk(input logic [NP-1:0] tv, input logic [NP-1:0] tl, input logic [7:0] tag,
                              input logic rdy, input logic ev, input logic [15:0] ed, input logic el,
                              input logic [NP-1:0] et);
    vec_t v;
    v.tv = tv; v.tl = tl; v.tag = tag; v.rdy = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_tready = et;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBus(input logic cs, input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    bus.chipselect = cs;
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = addr;
    bus.writedata  = wd;
  endtask

  // Port p always presents data {p, tag}; only the granted port is visible.
  task automatic applyStimulus(input logic [NP-1:0] tv, input logic [NP-1:0] tl, input logic [7:0] tag, input logic rdy);
    for (int p = 0; p < NP; p++) begin
      bus.ingress_port_tdata[16*p +: 16] = {8'(p), tag};
    end
    bus.ingress_port_tvalid = tv;
    bus.ingress_port_tlast  = tl;
    bus.egress_port_tready  = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [15:0] ed, input logic el, input logic [NP-1:0] et);
    checks++;
    if (bus.egress_port_tvalid !== ev || bus.egress_port_tdata !== ed ||
        bus.egress_port_tlast !== el || bus.ingress_port_tready !== et) begin
      errors++;
      $display("[TB] FAIL %s got valid=%0b data=%h last=%0b tready=%b want valid=%0b data=%h last=%0b tready=%b",
               name, bus.egress_port_tvalid, bus.egress_port_tdata, bus.egress_port_tlast,
               bus.ingress_port_tready, ev, ed, el, et);
    end
  endtask

  task automatic checkRead(input string name, input logic [7:0] expv);
    checks++;
    if (bus.readdata !== expv) begin
      errors++;
      $display("[TB] FAIL %s got readdata=%h want %h", name, bus.readdata, expv);
    end
  endtask

  task automatic step(input string name, input logic [NP-1:0] tv, input logic [NP-1:0] tl, input logic [7:0] tag,
                      input logic rdy, input logic ev, input logic [15:0] ed, input logic el, input logic [NP-1:0] et);
    applyStimulus(tv, tl, tag, rdy);
    checkOutput(name, ev, ed, el, et);
    tick();
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("%s[%0d]", name, i), vecs[i].tv, vecs[i].tl, vecs[i].tag, vecs[i].rdy,
           vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_last, vecs[i].exp_tready);
    end
    vecs.delete();
  endtask

  task automatic readReg(input logic [7:0] addr, input logic [7:0] expv, input string name);
    setBus(1'b1, 1'b1, 1'b0, addr, 8'h00);
    tick();
    setBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkRead(name, expv);
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
    setBus(1'b1, 1'b0, 1'b1, addr, data);
    tick();
    setBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus('0, '0, 8'h00, 1'b1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] regVal(input logic [7:0] addr);
    if (addr < NP) return cnt[addr];
    if (addr == 8'd8) return {owner >= 0, 3'b000, 4'(mgrant)};
    return 8'h00;
  endfunction

  task automatic randomRun(input int cycles);
    logic [NP-1:0] rtv, rtl, etr;
    logic          rrdy, rcs, rrd, rwr, rst_r, clr;
    logic [7:0]    raddr, rwd;
    logic          ev, el;
    logic [15:0]   ed;
    owner = -1; last_w = NP - 1; mgrant = 0; exp_rd = 8'h00;
    for (int p = 0; p < NP; p++) begin
      cnt[p] = 8'h00; beat[p] = 0; fno[p] = 0; flen[p] = $urandom_range(1, 4);
    end
    for (int c = 0; c < cycles; c++) begin
      rst_r = ($urandom_range(0, 299) == 0);
      reset = rst_r;
      for (int p = 0; p < NP; p++) begin
        rtv[p] = ($urandom_range(0, 3) != 0);
        rtl[p] = (beat[p] == flen[p] - 1);
        bus.ingress_port_tdata[16*p +: 16] = {4'(p), 4'(fno[p]), 8'(beat[p])};
      end
      rrdy = ($urandom_range(0, 3) != 0);
      rcs = 1'b0; rrd = 1'b0; rwr = 1'b0; raddr = 8'h00; rwd = 8'h00;
      case ($urandom_range(0, 15))
        0, 1, 2, 3: begin
          rcs = 1'b1; rrd = 1'b1;
          case ($urandom_range(0, 5))
            0, 1, 2, 3: raddr = 8'($urandom_range(0, NP - 1));
            4: raddr = 8'd8;
            default: raddr = 8'($urandom_range(0, 255));
          endcase
        end
        4: if ($urandom_range(0, 7) == 0) begin
          rcs = 1'b1; rwr = 1'b1; raddr = 8'd15; rwd = 8'($urandom_range(0, 255));
        end
        5: begin
          rcs = 1'b1; rwr = 1'b1; raddr = 8'($urandom_range(0, 255)); rwd = 8'($urandom_range(0, 255));
        end
        default: ;
      endcase
      bus.ingress_port_tvalid = rtv;
      bus.ingress_port_tlast  = rtl;
      bus.egress_port_tready  = rrdy;
      setBus(rcs, rrd, rwr, raddr, rwd);
      #1;
      ev = 1'b0; ed = 16'h0000; el = 1'b0; etr = '0;
      if (owner >= 0) begin
        ev = rtv[owner];
        ed = {4'(owner), 4'(fno[owner]), 8'(beat[owner])};
        el = rtl[owner];
        etr[owner] = rrdy;
      end
      checkOutput($sformatf("rand%0d", c), ev, ed, el, etr);
      tick();
      if (rst_r) begin
        owner = -1; last_w = NP - 1; mgrant = 0; exp_rd = 8'h00;
        for (int p = 0; p < NP; p++) begin
          cnt[p] = 8'h00; beat[p] = 0;
        end
      end else begin
        clr = rcs && rwr && (raddr == 8'd15) && rwd[0];
        if (rcs && rrd) exp_rd = regVal(raddr);
        if (owner < 0) begin
          for (int k = 1; k <= NP; k++) begin
            if (rtv[(last_w + k) % NP]) begin
              owner  = (last_w + k) % NP;
              mgrant = owner;
              break;
            end
          end
        end else if (rtv[owner] && rrdy && rtl[owner]) begin
          cnt[owner] = cnt[owner] + 8'd1;
          last_w     = owner;
          owner      = -1;
        end
        if (clr) begin
          for (int p = 0; p < NP; p++) cnt[p] = 8'h00;
        end
        for (int p = 0; p < NP; p++) begin
          if (rtv[p] && etr[p]) begin
            if (rtl[p]) begin
              fno[p]++; beat[p] = 0; flen[p] = $urandom_range(1, 4);
            end else begin
              beat[p]++;
            end
          end
        end
      end
      checkRead($sformatf("rand_rd%0d", c), exp_rd);
    end
    reset = 1'b0;
    setBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    setBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus('1, '0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("reset_outputs", 1'b0, 16'h0000, 1'b0, 4'b0000);
    checkRead("reset_readdata", 8'h00);
    reset = 1'b0;

    // Ports 0 and 2 each send a 3-beat frame.
    vecs.push_back(mk(4'b0101, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b0101, 4'b0000, 8'h00, 1'b1, 1'b1, 16'h0000, 1'b0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0000, 8'h01, 1'b1, 1'b1, 16'h0001, 1'b0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0001, 8'h02, 1'b1, 1'b1, 16'h0002, 1'b1, 4'b0001));
    vecs.push_back(mk(4'b0100, 4'b0000, 8'h10, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 8'h10, 1'b1, 1'b1, 16'h0210, 1'b0, 4'b0100));
    vecs.push_back(mk(4'b0100, 4'b0000, 8'h11, 1'b1, 1'b1, 16'h0211, 1'b0, 4'b0100));
    vecs.push_back(mk(4'b0100, 4'b0100, 8'h12, 1'b1, 1'b1, 16'h0212, 1'b1, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000));
    runTable("two_ports");
    readReg(8'd0, 8'd1, "two_ports_cnt0");
    readReg(8'd1, 8'd0, "two_ports_cnt1");
    readReg(8'd2, 8'd1, "two_ports_cnt2");

    // All ports request 2-beat frames back to back: grant order 0,1,2,3,0.
    doReset();
    for (int f = 0; f < 5; f++) begin
      vecs.push_back(mk(4'b1111, 4'b0000, 8'(2*f), 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000));
      vecs.push_back(mk(4'b1111, 4'b0000, 8'(2*f), 1'b1, 1'b1, {8'(f % NP), 8'(2*f)}, 1'b0, 4'(1 << (f % NP))));
      vecs.push_back(mk(4'b1111, 4'b1111, 8'(2*f+1), 1'b1, 1'b1, {8'(f % NP), 8'(2*f+1)}, 1'b1, 4'(1 << (f % NP))));
    end
    vecs.push_back(mk(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000));
    runTable("all_ports");
    readReg(8'd0, 8'd2, "all_ports_cnt0");
    readReg(8'd3, 8'd1, "all_ports_cnt3");
    readReg(8'd9, 8'd0, "unmapped_addr");

    // Port 1 stalls downstream, then drops valid while port 3 waits.
    doReset();
    step("stall_idle", 4'b1010, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    step("stall_b0", 4'b1010, 4'b0000, 8'h00, 1'b1, 1'b1, 16'h0100, 1'b0, 4'b0010);
    for (int i = 0; i < 5; i++) step("stall_hold", 4'b1010, 4'b0000, 8'h01, 1'b0, 1'b1, 16'h0101, 1'b0, 4'b0000);
    for (int i = 0; i < 2; i++) step("stall_drop", 4'b1000, 4'b0000, 8'h01, 1'b1, 1'b0, 16'h0101, 1'b0, 4'b0010);
    step("stall_last", 4'b1010, 4'b0010, 8'h02, 1'b1, 1'b1, 16'h0102, 1'b1, 4'b0010);
    step("stall_bubble", 4'b1000, 4'b0000, 8'h03, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    step("stall_p3", 4'b1000, 4'b1000, 8'h03, 1'b1, 1'b1, 16'h0303, 1'b1, 4'b1000);
    step("stall_end", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);

    // 256 single-beat frames wrap counter 0; address 8 read while port 2 busy.
    doReset();
    for (int i = 0; i < 256; i++) begin
      step("wrap_idle", 4'b0001, 4'b0001, 8'(i), 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
      step("wrap_beat", 4'b0001, 4'b0001, 8'(i), 1'b1, 1'b1, {8'h00, 8'(i)}, 1'b1, 4'b0001);
    end
    step("wrap_end", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    readReg(8'd0, 8'h00, "wrap_cnt0");
    step("busy_idle", 4'b0100, 4'b0000, 8'h20, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    setBus(1'b1, 1'b1, 1'b0, 8'd8, 8'h00);
    step("busy_hold", 4'b0100, 4'b0000, 8'h20, 1'b0, 1'b1, 16'h0220, 1'b0, 4'b0000);
    setBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkRead("status_busy", 8'h82);
    step("busy_last", 4'b0100, 4'b0100, 8'h21, 1'b1, 1'b1, 16'h0221, 1'b1, 4'b0100);
    step("busy_end", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    readReg(8'd8, 8'h02, "status_idle");

    // Ignored write, then clear coinciding with a port 1 tlast handshake.
    doReset();
    step("clr_idle0", 4'b0010, 4'b0010, 8'h50, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    step("clr_beat0", 4'b0010, 4'b0010, 8'h50, 1'b1, 1'b1, 16'h0150, 1'b1, 4'b0010);
    applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
    writeReg(8'd14, 8'h01);
    readReg(8'd1, 8'd1, "write_ignored");
    step("clr_idle1", 4'b0010, 4'b0010, 8'h55, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    setBus(1'b1, 1'b0, 1'b1, 8'd15, 8'h01);
    step("clr_beat1", 4'b0010, 4'b0010, 8'h55, 1'b1, 1'b1, 16'h0155, 1'b1, 4'b0010);
    setBus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step("clr_end", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    readReg(8'd1, 8'd0, "clear_wins");

    // Reset lands during beat 2 of a port 3 frame.
    doReset();
    step("rst_idle", 4'b1000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    step("rst_b0", 4'b1000, 4'b0000, 8'h00, 1'b1, 1'b1, 16'h0300, 1'b0, 4'b1000);
    reset = 1'b1;
    step("rst_b1", 4'b1001, 4'b0000, 8'h01, 1'b1, 1'b1, 16'h0301, 1'b0, 4'b1000);
    reset = 1'b0;
    step("rst_after", 4'b1001, 4'b0000, 8'h02, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    step("rst_p0", 4'b1001, 4'b1001, 8'h03, 1'b1, 1'b1, 16'h0003, 1'b1, 4'b0001);
    step("rst_end", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);

    doReset();
    randomRun(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
